// File: rtl/id_ibuf_pkg.sv
// rtl/id_ibuf_pkg.sv - shared defaults and entry-layout helpers for the IF->ID instruction buffer
package id_ibuf_pkg;

    localparam int IBUF_DEF_DEPTH  = 4;
    localparam int IBUF_DEF_INST_W = 32;
    localparam int IBUF_DEF_PC_W   = 32;

    // Entry layout is {excep, inst, pc}: pc in the low bits, exception tag on top.
    function automatic int ibuf_entry_len(input int inst_w, input int pc_w);
        return inst_w + pc_w + 1;
    endfunction

    function automatic int ibuf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ibuf_mem.sv
// rtl/ibuf_mem.sv - unreset entry array, one synchronous write port and one asynchronous read port
module ibuf_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 65,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/id_ibuf.sv
// rtl/id_ibuf.sv - IF->ID instruction queue with flush and fault halt; IBUF_BYPASS_EN enables empty-queue forwarding
module id_ibuf
    import id_ibuf_pkg::*;
#(
    parameter int  DEPTH  = IBUF_DEF_DEPTH,
    parameter int  INST_W = IBUF_DEF_INST_W,
    parameter int  PC_W   = IBUF_DEF_PC_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_excep,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_excep,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              halted
);

    localparam int ENTRY_W = ibuf_entry_len(INST_W, PC_W);
    localparam int PTR_W   = ibuf_ptr_w(DEPTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_halted;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_enq;
    logic               w_deq;
    logic               w_wr_inc;
    logic               w_rd_inc;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef IBUF_BYPASS_EN
    assign w_bypass = w_empty & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // in_ready deliberately ignores out_ready so no comb path exists from ID back to IF.
    assign in_ready  = ~w_full & ~r_halted & ~flush;
    assign out_valid = w_bypass ? (in_valid & ~r_halted) : (~w_empty & ~flush);

    assign w_enq = in_valid & in_ready;
    assign w_deq = out_valid & out_ready;

    // A bypassed entry consumed in the same cycle never touches storage or pointers.
    assign w_wr_inc = w_enq & ~(w_bypass & w_deq);
    assign w_rd_inc = w_deq & ~w_bypass;

    assign w_wr_entry = {in_excep, in_inst, in_pc};
    assign w_head     = w_bypass ? w_wr_entry : w_rd_entry;

    ibuf_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_inc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_wr_inc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_inc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_inc && !w_rd_inc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_rd_inc && !w_wr_inc) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_enq && in_excep) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Head data is zeroed when not valid so unwritten storage never reaches ID.
    assign out_excep = out_valid ? w_head[ENTRY_W-1] : 1'b0;
    assign out_inst  = out_valid ? w_head[PC_W +: INST_W] : '0;
    assign out_pc    = out_valid ? w_head[PC_W-1:0] : '0;
    assign count     = r_count;
    assign halted    = r_halted;

    a_count_bound : assert property (@(posedge clk) disable iff (!resetn) r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_id_ibuf.sv
// tb/tb_id_ibuf.sv - self-checking bench for id_ibuf: vector table, directed corner cases, randomized queue model
module tb_id_ibuf;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_excep;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_excep;
    logic        flush;
    logic [2:0]  count;
    logic        halted;

    id_ibuf #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_excep  (in_excep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_excep (out_excep),
        .flush     (flush),
        .count     (count),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        excep;
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    ent_t mq[$];
    bit   m_halted;
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hdead_beef;
    endfunction

    // One clock of stimulus; the queue model predicts outputs and is advanced after the edge.
    task automatic cycle(input logic iv, input logic ie, input logic [31:0] pc,
                         input logic ordy, input logic fl,
                         output logic s_ir, output logic s_ov, output logic [31:0] s_pc);
        int   n;
        bit   byp;
        bit   e_ir;
        bit   e_ov;
        ent_t e_head;
        bit   enq;
        bit   deq;
        in_valid  = iv;
        in_excep  = ie;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
        n    = mq.size();
        byp  = 1'b0;
`ifdef IBUF_BYPASS_EN
        byp  = (n == 0) && !fl;
`endif
        e_ir = (n != DEPTH) && !m_halted && !fl;
        if (byp) begin
            e_ov   = iv && !m_halted;
            e_head = '{excep: ie, inst: inst_of(pc), pc: pc};
        end else begin
            e_ov   = (n != 0) && !fl;
            e_head = (n != 0) ? mq[0] : '{excep: 1'b0, inst: 32'h0, pc: 32'h0};
        end
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("count", count, n);
        chk("halted", halted, m_halted);
        if (e_ov) begin
            chk("out_pc", out_pc, e_head.pc);
            chk("out_inst", out_inst, e_head.inst);
            chk("out_excep", out_excep, e_head.excep);
        end
        s_ir = in_ready;
        s_ov = out_valid;
        s_pc = out_pc;
        enq  = iv && e_ir;
        deq  = e_ov && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (!(byp && enq && deq)) begin
                if (deq) void'(mq.pop_front());
                if (enq) mq.push_back('{excep: ie, inst: inst_of(pc), pc: pc});
            end
            if (enq && ie) m_halted = 1'b1;
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_excep  = 1'b0;
        in_pc     = 32'h0;
        in_inst   = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mq.delete();
        m_halted = 1'b0;
    endtask

    logic        s_ir;
    logic        s_ov;
    logic [31:0] s_pc;
    vec_t        tbl[12];

    initial begin
        n_pass  = 0;
        n_total = 0;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_excep  = 1'b0;
        in_pc     = 32'h0;
        in_inst   = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_excep", out_excep, 0);
        do_reset();

`ifndef IBUF_BYPASS_EN
        // Fill to full, refuse while full, then drain with pointer wrap.
        tbl[0]  = '{1'b1, 32'h1c000000, 1'b0, 1'b1, 1'b0, 32'h0,        1};
        tbl[1]  = '{1'b1, 32'h1c000004, 1'b0, 1'b1, 1'b1, 32'h1c000000, 2};
        tbl[2]  = '{1'b1, 32'h1c000008, 1'b0, 1'b1, 1'b1, 32'h1c000000, 3};
        tbl[3]  = '{1'b1, 32'h1c00000c, 1'b0, 1'b1, 1'b1, 32'h1c000000, 4};
        tbl[4]  = '{1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b1, 32'h1c000000, 4};
        tbl[5]  = '{1'b1, 32'h1c000010, 1'b1, 1'b0, 1'b1, 32'h1c000000, 3};
        tbl[6]  = '{1'b1, 32'h1c000010, 1'b1, 1'b1, 1'b1, 32'h1c000004, 3};
        tbl[7]  = '{1'b1, 32'h1c000014, 1'b1, 1'b1, 1'b1, 32'h1c000008, 3};
        tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1c00000c, 2};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1c000010, 1};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1c000014, 0};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, 1'b0, tbl[i].pc, tbl[i].ordy, 1'b0, s_ir, s_ov, s_pc);
            chk($sformatf("tbl%0d_in_ready", i), s_ir, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_pc", i), s_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
        end
`endif

        // Simultaneous push/pop at count=2 keeps occupancy and order.
        do_reset();
        cycle(1'b1, 1'b0, 32'h1c000000, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        cycle(1'b1, 1'b0, 32'h1c000004, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h1c000008 + 32'(4 * i), 1'b1, 1'b0, s_ir, s_ov, s_pc);
            chk("simul_head", s_pc, 32'h1c000000 + 32'(4 * i));
            chk("simul_count", count, 2);
        end

        // Flush with a pending push: nothing moves, queue empties, next push becomes head.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h1c000000 + 32'(4 * i), 1'b0, 1'b0, s_ir, s_ov, s_pc);
        cycle(1'b1, 1'b0, 32'h1c0000f0, 1'b1, 1'b1, s_ir, s_ov, s_pc);
        chk("flush_in_ready", s_ir, 0);
        chk("flush_out_valid", s_ov, 0);
        chk("flush_count_after", count, 0);
        cycle(1'b1, 1'b0, 32'h1c000100, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        chk("post_flush_in_ready", s_ir, 1);
`ifndef IBUF_BYPASS_EN
        chk("post_flush_out_valid", s_ov, 0);
`endif
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, s_ir, s_ov, s_pc);
        chk("post_flush_head", s_pc, 32'h1c000100);

        // Faulting fetch halts intake; queued entries still drain; only flush clears it.
        do_reset();
        cycle(1'b1, 1'b0, 32'h1c000000, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        cycle(1'b1, 1'b1, 32'h1c000004, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        chk("halt_set", halted, 1);
        cycle(1'b1, 1'b0, 32'h1c000008, 1'b1, 1'b0, s_ir, s_ov, s_pc);
        chk("halt_in_ready", s_ir, 0);
        chk("halt_drain0_pc", s_pc, 32'h1c000000);
        in_valid = 1'b0;
        #1;
        chk("halt_drain1_pc", out_pc, 32'h1c000004);
        chk("halt_drain1_excep", out_excep, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, s_ir, s_ov, s_pc);
        chk("halt_drained_count", count, 0);
        chk("halt_kept", halted, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, s_ir, s_ov, s_pc);
        chk("halt_cleared", halted, 0);
        cycle(1'b1, 1'b0, 32'h1c000200, 1'b0, 1'b0, s_ir, s_ov, s_pc);
        chk("halt_resume_in_ready", s_ir, 1);

        // Asynchronous reset mid-cycle with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h1c000000 + 32'(4 * i), 1'b0, 1'b0, s_ir, s_ov, s_pc);
        chk("pre_async_count", count, 3);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_halted", halted, 0);
        chk("async_in_ready", in_ready, 1);
        do_reset();

`ifdef IBUF_BYPASS_EN
        cycle(1'b1, 1'b0, 32'h1c000300, 1'b1, 1'b0, s_ir, s_ov, s_pc);
        chk("bypass_out_valid", s_ov, 1);
        chk("bypass_out_pc", s_pc, 32'h1c000300);
        chk("bypass_count", count, 0);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  $urandom(),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                  s_ir, s_ov, s_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ibuf.md
Name: id_ibuf

Overview:
Parametrised instruction buffer between IF and ID. It decouples fetch from decode stalls by queuing up to DEPTH {inst, pc, excep} entries, with valid/ready handshakes on both sides. It flushes on branch/exception redirect, and stops accepting fetches after a faulting entry until the next flush. ID consumes the queue head in place of the single IF->ID pipeline register.

Parameters:
DEPTH, 4, entry count; power of 2, >= 2
INST_W, 32, instruction width
PC_W, 32, PC width
CNT_W (localparam), $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous reset, active-low
in_valid  in  1  IF offers an entry
in_ready  out  1  buffer accepts an entry this cycle
in_inst  in  INST_W  fetched instruction
in_pc  in  PC_W  PC of fetched instruction
in_excep  in  1  fetch exception (e.g. ADEF) tagged on this entry
out_valid  out  1  head entry is valid for ID
out_ready  in  1  ID consumes head (ID_allow_in)
out_inst  out  INST_W  head instruction
out_pc  out  PC_W  head PC
out_excep  out  1  head exception tag
flush  in  1  redirect (br_taken or exception/ertn); discard all contents
count  out  CNT_W  current occupancy, 0..DEPTH
halted  out  1  a faulting entry has been accepted; fetch is blocked

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous, active-low.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, halted=0.
- Reset outputs: out_valid=0, in_ready=1, out_* data 0.
- Storage data is not reset.
- enq = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = ~full & ~halted & ~flush, where full = (count==DEPTH). There is no combinational path from out_ready to in_ready; a full buffer refuses input even when the head is dequeued in the same cycle.
- out_valid = (count!=0) & ~flush. out_inst/out_pc/out_excep come from mem[rd_ptr] and are stable while out_valid & ~out_ready.
- Enqueue: write mem[wr_ptr]; wr_ptr wraps modulo DEPTH (pointer width $clog2(DEPTH), natural wrap).
- Dequeue: rd_ptr increments modulo DEPTH.
- count: +1 on enq only, -1 on deq only, unchanged on simultaneous enq & deq.
- Latency without bypass: entry enqueued in cycle N is visible at out in cycle N+1 at the earliest.
- halted: set on an enq with in_excep=1; cleared only by flush. Entries already queued ahead of the fault still drain normally. Dequeue does not clear halted.
- flush, highest priority:
  - next-cycle wr_ptr=rd_ptr=0, count=0, halted=0;
  - in_ready and out_valid are forced 0 in the flush cycle, so no enq or deq happens;
  - in the cycle after flush, out_valid=0 and in_ready=1.
- Reset mid-operation: all state returns to reset values immediately (async); contents are lost.
- Overflow/underflow cannot occur by construction; an assertion checks count <= DEPTH.

Optional Feature:
Macro IBUF_BYPASS_EN.
- Defined: when count==0 and ~flush, the input is forwarded combinationally.
  - out_valid = in_valid & ~halted;
  - out_* = in_*;
  - if out_ready, the entry is consumed with no write and count stays 0 (zero-latency);
  - if ~out_ready, the entry is written normally.
  - halted still sets if the bypassed entry has in_excep=1.
- Undefined: strict 1-cycle minimum latency as above; no comb path from in_* to out_*.

Decomposition:
- macro.vh gains `IBUF_ENTRY_LEN (INST_W+PC_W+1 = 65).
- Entry packing is {excep, inst, pc}, matching the existing IFreg_bus ordering of {inst, pc} with excep prepended.
- One sub-module, ibuf_mem: DEPTH x `IBUF_ENTRY_LEN register array with one synchronous write port and one async read port, no reset.
- Pointer/count/halted control stays in id_ibuf.

Test Plan:
- Fill: DEPTH=4, out_ready=0, push PCs 0x1c000000..0x1c00000c → count=4, in_ready=0. Pushing 0x1c000010 is not accepted; out_pc=0x1c000000.
- Drain with wrap: from full, out_ready=1 for 6 cycles while pushing 0x1c000010/14 → outputs appear in order 0x..00,04,08,0c,10,14; count returns to 0; pointers wrap past 3.
- Simultaneous: count=2 with in_valid=out_ready=1 each cycle for 10 cycles → count stays 2 and order is preserved.
- Flush: count=3 with in_valid=1, flush=1 → that cycle in_ready=0 and out_valid=0. Next cycle count=0 and out_valid=0; the new entry 0x1c000100 is accepted and is the next head.
- Exception halt: push 0x1c000000 (excep=0), then 0x1c000004 (excep=1) → halted=1, in_ready=0. Both entries drain in order with out_excep=0 then 1. After flush, halted=0 and in_ready=1.
- Async reset: assert resetn=0 mid-cycle with count=3 → immediately count=0, out_valid=0, halted=0. With IBUF_BYPASS_EN, empty + out_ready=1 → in_pc appears on out_pc the same cycle and count stays 0.
